// File: rtl/alu_switch_ctrl_param_pkg.sv
// Package alu_switch_pkg: shared definitions for the switch/button ALU front end.
//   - opcode codes (6-bit, zero-extended when the opcode field is wider)
//   - FSM state enum
//   - status flag bundle
package alu_switch_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_switch_ctrl_param_if.sv
// Board I/O bundle of the switch/button ALU.
//   SWITCH  shared data/opcode input (async to CLK)
//   BOT     buttons: [0] load A, [1] load B, [2] load opcode + execute
//   LED     registered result
//   FLAG_Z/FLAG_C/FLAG_V  zero / carry-borrow / signed overflow
//   OP_ERR  last executed opcode unsupported
//   VALID   one-cycle pulse when LED/flags update
// Modports: master = board/stimulus side, slave = ALU controller side.
interface alu_switch_ctrl_param_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] SWITCH;
  logic [2:0]        BOT;
  logic [N_BITS-1:0] LED;
  logic              FLAG_Z;
  logic              FLAG_C;
  logic              FLAG_V;
  logic              OP_ERR;
  logic              VALID;

  modport master (
    output SWITCH, BOT,
    input  LED, FLAG_Z, FLAG_C, FLAG_V, OP_ERR, VALID
  );

  modport slave (
    input  SWITCH, BOT,
    output LED, FLAG_Z, FLAG_C, FLAG_V, OP_ERR, VALID
  );
endinterface

// File: rtl/alu_switch_ctrl_param_btn_sync_edge.sv
// btn_sync_edge: conditioning for one asynchronous push-button.
//   2-FF synchroniser -> optional counter debouncer -> rising-edge detect.
//   Debouncer compiled in only when BOT_DEBOUNCE_EN is defined; the debounced
//   level then changes after DEBOUNCE_CYCLES consecutive differing samples.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   btn    raw button level
//   rise   one-cycle pulse on a (debounced) rising edge
module btn_sync_edge #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync1, sync2, level, prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef BOT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          deb;

  // cnt counts consecutive samples that disagree with the current level;
  // any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      deb <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = deb;
`else
  logic unused_dc;
  assign unused_dc = (DEBOUNCE_CYCLES != 0);
  assign level     = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/alu_switch_ctrl_param.sv
// alu_switch_ctrl_param: switch/button ALU front end.
//   Operands A, B and the opcode are latched from the shared SWITCH bus by
//   buttons BOT[0..2]; an opcode press runs one registered ALU operation
//   (IDLE -> EXEC -> IDLE) and presents LED/flags with a one-cycle VALID.
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   io     alu_switch_ctrl_param_if.slave (SWITCH, BOT in; LED, flags, VALID out)
// Optional feature: BOT_DEBOUNCE_EN adds a per-button debouncer
//   (DEBOUNCE_CYCLES samples) inside btn_sync_edge.
module alu_switch_ctrl_param
  import alu_switch_pkg::*;
#(
  parameter int N_BITS          = 8,
  parameter int N_OP            = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  alu_switch_ctrl_param_if.slave  io
);

  typedef struct packed {
    logic [N_BITS-1:0] res;
    flags_t            f;
  } alu_out_t;

  logic [2:0]        rise;
  state_t            state;
  logic [N_BITS-1:0] a, b, led;
  logic [N_OP-1:0]   op;
  flags_t            flags;
  logic              valid;
  alu_out_t          alu;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (CLK),
      .rst_n (RST_N),
      .btn   (io.BOT[i]),
      .rise  (rise[i])
    );
  end

  function automatic alu_out_t alu_eval(
    input logic [N_BITS-1:0] x,
    input logic [N_BITS-1:0] y,
    input logic [N_OP-1:0]   code
  );
    alu_out_t        o;
    logic [N_BITS:0] wide;
    logic            big_shift;
    o         = '0;
    wide      = '0;
    big_shift = (32'(y) >= 32'(N_BITS));
    case (32'(code))
      32'(OP_ADD): begin
        wide    = {1'b0, x} + {1'b0, y};
        o.res   = wide[N_BITS-1:0];
        o.f.c   = wide[N_BITS];
        o.f.v   = (x[N_BITS-1] == y[N_BITS-1]) && (o.res[N_BITS-1] != x[N_BITS-1]);
      end
      32'(OP_SUB): begin
        // Borrow falls out as the top bit of the widened difference.
        wide    = {1'b0, x} - {1'b0, y};
        o.res   = wide[N_BITS-1:0];
        o.f.c   = wide[N_BITS];
        o.f.v   = (x[N_BITS-1] != y[N_BITS-1]) && (o.res[N_BITS-1] != x[N_BITS-1]);
      end
      32'(OP_AND): o.res = x & y;
      32'(OP_OR):  o.res = x | y;
      32'(OP_XOR): o.res = x ^ y;
      32'(OP_NOR): o.res = ~(x | y);
      32'(OP_SRL): o.res = big_shift ? '0 : (x >> y);
      32'(OP_SRA): o.res = big_shift ? {N_BITS{x[N_BITS-1]}}
                                     : N_BITS'($signed(x) >>> y);
      default:     o.f.err = 1'b1;
    endcase
    o.f.z = (o.res == '0);
    return o;
  endfunction

  always_comb begin
    alu = alu_eval(a, b, op);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      led   <= '0;
      flags <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise[0]) a <= io.SWITCH;
      if (rise[1]) b <= io.SWITCH;
      case (state)
        IDLE: begin
          if (rise[2]) begin
            op    <= io.SWITCH[N_OP-1:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          led   <= alu.res;
          flags <= alu.f;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.LED    = led;
  assign io.FLAG_Z = flags.z;
  assign io.FLAG_C = flags.c;
  assign io.FLAG_V = flags.v;
  assign io.OP_ERR = flags.err;
  assign io.VALID  = valid;

endmodule
